shot_entry_ctrl: RTL and testbench



---
 rtl/shot_entry_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_shot_entry_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/shot_entry_ctrl.sv
// Keypad shot entry: debounces raw decoder codes into single press events and
// walks row -> column -> confirm, then offers the coordinate over valid/ready.
module shot_entry_ctrl #(
    parameter int          GRID_SIZE       = 8,
    parameter int          DEBOUNCE_CYCLES = 1_000_000,
    parameter logic [3:0]  CLEAR_KEY       = 4'hE,
    parameter logic [3:0]  CONFIRM_KEY     = 4'hF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] key,
    input  logic       key_down,
    input  logic       entry_en,
    input  logic       shot_ready,
    output logic       shot_valid,
    output logic [3:0] shot_row,
    output logic [3:0] shot_col,
    output logic       row_set,
    output logic       col_set,
    output logic [3:0] disp_row,
    output logic [3:0] disp_col,
    output logic       key_err
);
    localparam int         CW     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [3:0] GRID_L = 4'(GRID_SIZE);

    typedef enum logic [1:0] {ROW, COL, CONF, SEND} state_t;

    logic [3:0]    key_s1, key_s2, last_key;
    logic          kd_s1, kd_s2, last_kd;
    logic          armed;
    logic [CW-1:0] cnt;
    logic          press_evt;
    logic [3:0]    press_code;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_s1   <= '0;
            key_s2   <= '0;
            last_key <= '0;
            kd_s1    <= 1'b0;
            kd_s2    <= 1'b0;
            last_kd  <= 1'b0;
        end else begin
            key_s1   <= key;
            key_s2   <= key_s1;
            last_key <= key_s2;
            kd_s1    <= key_down;
            kd_s2    <= kd_s1;
            last_kd  <= kd_s2;
        end
    end

    // Armed: count stable held samples toward a press. Disarmed: count
    // released samples toward re-arm, so a held key fires only once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed      <= 1'b0;
            cnt        <= '0;
            press_evt  <= 1'b0;
            press_code <= '0;
        end else begin
            press_evt <= 1'b0;
            if (armed) begin
                if (!kd_s2) begin
                    cnt <= '0;
                end else if (!last_kd || key_s2 != last_key) begin
                    cnt <= CW'(1);
                end else if (cnt == CNT_LAST) begin
                    press_evt  <= 1'b1;
                    press_code <= key_s2;
                    armed      <= 1'b0;
                    cnt        <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                if (kd_s2) begin
                    cnt <= '0;
                end else if (cnt == CNT_LAST) begin
                    armed <= 1'b1;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    state_t state, nxt;
    logic   evt, is_digit, is_clear, is_conf;

    assign evt      = press_evt && entry_en;
    assign is_digit = press_code < GRID_L;
    assign is_clear = press_code == CLEAR_KEY;
    assign is_conf  = press_code == CONFIRM_KEY;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ROW;
        else        state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            ROW:  if (evt && is_digit) nxt = COL;
            COL:  if (evt && is_digit) nxt = CONF;
                  else if (evt && is_clear) nxt = ROW;
            CONF: if (evt && is_conf) nxt = SEND;
                  else if (evt && is_clear) nxt = ROW;
            SEND: if (shot_ready) nxt = ROW;
            default: nxt = ROW;
        endcase
    end

    logic       n_valid, n_row_set, n_col_set, n_err;
    logic [3:0] n_shot_row, n_shot_col, n_disp_row, n_disp_col;

    always_comb begin
        n_valid    = shot_valid;
        n_shot_row = shot_row;
        n_shot_col = shot_col;
        n_row_set  = row_set;
        n_col_set  = col_set;
        n_disp_row = disp_row;
        n_disp_col = disp_col;
        n_err      = 1'b0;
        case (state)
            ROW: if (evt) begin
                if (is_digit) begin
                    n_disp_row = press_code;
                    n_row_set  = 1'b1;
                end else if (!is_clear) begin
                    n_err = 1'b1;
                end
            end
            COL: if (evt) begin
                if (is_digit) begin
                    n_disp_col = press_code;
                    n_col_set  = 1'b1;
                end else if (is_clear) begin
                    n_row_set  = 1'b0;
                    n_col_set  = 1'b0;
                    n_disp_row = '0;
                    n_disp_col = '0;
                end else begin
                    n_err = 1'b1;
                end
            end
            CONF: if (evt) begin
                if (is_conf) begin
                    n_shot_row = disp_row;
                    n_shot_col = disp_col;
                    n_valid    = 1'b1;
                end else if (is_clear) begin
                    n_row_set  = 1'b0;
                    n_col_set  = 1'b0;
                    n_disp_row = '0;
                    n_disp_col = '0;
                end else if (is_digit) begin
                    n_disp_col = press_code;
                end else begin
                    n_err = 1'b1;
                end
            end
            SEND: if (shot_ready) begin
                n_valid    = 1'b0;
                n_row_set  = 1'b0;
                n_col_set  = 1'b0;
                n_disp_row = '0;
                n_disp_col = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shot_valid <= 1'b0;
            shot_row   <= '0;
            shot_col   <= '0;
            row_set    <= 1'b0;
            col_set    <= 1'b0;
            disp_row   <= '0;
            disp_col   <= '0;
            key_err    <= 1'b0;
        end else begin
            shot_valid <= n_valid;
            shot_row   <= n_shot_row;
            shot_col   <= n_shot_col;
            row_set    <= n_row_set;
            col_set    <= n_col_set;
            disp_row   <= n_disp_row;
            disp_col   <= n_disp_col;
            key_err    <= n_err;
        end
    end
endmodule

// File: tb/tb_shot_entry_ctrl.sv
// Scenario bench for shot_entry_ctrl; delivered shots are checked against a
// queue of expected coordinates filled as each confirm is driven.
module tb_shot_entry_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] key = '0;
    logic       key_down = 1'b0;
    logic       entry_en = 1'b1;
    logic       shot_ready = 1'b1;
    logic       shot_valid, row_set, col_set, key_err;
    logic [3:0] shot_row, shot_col, disp_row, disp_col;

    typedef struct { logic [3:0] r; logic [3:0] c; } shot_t;
    shot_t exp_q[$];
    shot_t mon_e;
    int    n_checks = 0;
    int    n_fail   = 0;
    int    beats    = 0;

    shot_entry_ctrl #(.GRID_SIZE(8), .DEBOUNCE_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .key(key), .key_down(key_down),
        .entry_en(entry_en), .shot_ready(shot_ready), .shot_valid(shot_valid),
        .shot_row(shot_row), .shot_col(shot_col), .row_set(row_set),
        .col_set(col_set), .disp_row(disp_row), .disp_col(disp_col),
        .key_err(key_err)
    );

    always #5 clk = ~clk;

    // Every accepted beat must match the oldest expected shot.
    always @(negedge clk) begin
        if (rst_n && shot_valid && shot_ready) begin
            beats++;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL shot_unexpected: got row=%0d col=%0d, expected no shot", shot_row, shot_col);
            end else begin
                mon_e = exp_q.pop_front();
                if (shot_row !== mon_e.r || shot_col !== mon_e.c) begin
                    n_fail++;
                    $display("FAIL shot_data: got row=%0d col=%0d, expected row=%0d col=%0d",
                             shot_row, shot_col, mon_e.r, mon_e.c);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One clean press/release; returns the number of cycles key_err was high.
    task automatic press(input logic [3:0] c, output int errs);
        errs = 0;
        @(posedge clk); #1 key = c; key_down = 1'b1;
        repeat (10) begin @(negedge clk); if (key_err) errs++; end
        @(posedge clk); #1 key_down = 1'b0;
        repeat (10) begin @(negedge clk); if (key_err) errs++; end
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (shot_valid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        n_checks++;
        if (shot_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_timeout: shot_valid=%b after %0d cycles, expected 1", name, shot_valid, n);
        end
    endtask

    task automatic check_all_zero(input string name);
        n_checks++;
        if ({shot_valid, shot_row, shot_col, row_set, col_set, disp_row, disp_col, key_err} !== '0) begin
            n_fail++;
            $display("FAIL %s: outputs v=%b r=%0d c=%0d rs=%b cs=%b dr=%0d dc=%0d err=%b, expected all 0",
                     name, shot_valid, shot_row, shot_col, row_set, col_set, disp_row, disp_col, key_err);
        end
    endtask

    task automatic test_reset;
        #1 check_all_zero("reset_state");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle(8);
        check_all_zero("post_reset_idle");
    endtask

    task automatic test_basic_shot;
        int e;
        shot_ready = 1'b1;
        press(4'd3, e);
        n_checks++;
        if (row_set !== 1'b1 || disp_row !== 4'd3) begin
            n_fail++; $display("FAIL basic_row: rs=%b dr=%0d, expected 1 3", row_set, disp_row);
        end
        press(4'd5, e);
        n_checks++;
        if (col_set !== 1'b1 || disp_col !== 4'd5) begin
            n_fail++; $display("FAIL basic_col: cs=%b dc=%0d, expected 1 5", col_set, disp_col);
        end
        exp_q.push_back('{r: 4'd3, c: 4'd5});
        press(4'hF, e);
        n_checks++;
        if (shot_valid !== 1'b0 || row_set !== 1'b0 || col_set !== 1'b0 || disp_row !== 4'd0 || e != 0) begin
            n_fail++;
            $display("FAIL basic_after: v=%b rs=%b cs=%b dr=%0d errs=%0d, expected 0 0 0 0 0",
                     shot_valid, row_set, col_set, disp_row, e);
        end
    endtask

    task automatic test_bounce;
        int e;
        @(posedge clk); #1 key = 4'd2;
        repeat (20) begin @(posedge clk); #1 key_down = ~key_down; end
        key_down = 1'b0;
        @(negedge clk);
        n_checks++;
        if (row_set !== 1'b0) begin
            n_fail++; $display("FAIL bounce_no_event: rs=%b, expected 0", row_set);
        end
        idle(8);
        @(posedge clk); #1 key_down = 1'b1;
        repeat (100) @(negedge clk);
        n_checks++;
        if (row_set !== 1'b1 || disp_row !== 4'd2 || col_set !== 1'b0) begin
            n_fail++;
            $display("FAIL bounce_hold_one_event: rs=%b dr=%0d cs=%b, expected 1 2 0", row_set, disp_row, col_set);
        end
        @(posedge clk); #1 key_down = 1'b0;
        idle(10);
        press(4'hE, e);
        n_checks++;
        if (row_set !== 1'b0 || disp_row !== 4'd0 || e != 0) begin
            n_fail++; $display("FAIL clear_in_col: rs=%b dr=%0d errs=%0d, expected 0 0 0", row_set, disp_row, e);
        end
    endtask

    task automatic test_invalid;
        int e;
        press(4'd9, e);
        n_checks++;
        if (e != 1 || row_set !== 1'b0) begin
            n_fail++; $display("FAIL invalid_digit_row: errs=%0d rs=%b, expected 1 0", e, row_set);
        end
        press(4'hF, e);
        n_checks++;
        if (e != 1 || row_set !== 1'b0) begin
            n_fail++; $display("FAIL confirm_in_row: errs=%0d rs=%b, expected 1 0", e, row_set);
        end
        press(4'hE, e);
        n_checks++;
        if (e != 0 || row_set !== 1'b0) begin
            n_fail++; $display("FAIL clear_in_row: errs=%0d rs=%b, expected 0 0", e, row_set);
        end
    endtask

    task automatic test_correction;
        int e;
        shot_ready = 1'b1;
        press(4'd1, e);
        press(4'd6, e);
        press(4'd2, e);
        n_checks++;
        if (e != 0 || disp_col !== 4'd2 || col_set !== 1'b1) begin
            n_fail++; $display("FAIL correction_col: errs=%0d dc=%0d cs=%b, expected 0 2 1", e, disp_col, col_set);
        end
        exp_q.push_back('{r: 4'd1, c: 4'd2});
        press(4'hF, e);
        press(4'd4, e);
        press(4'hE, e);
        n_checks++;
        if (row_set !== 1'b0 || col_set !== 1'b0 || disp_row !== 4'd0 || shot_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_entry: rs=%b cs=%b dr=%0d v=%b, expected 0 0 0 0", row_set, col_set, disp_row, shot_valid);
        end
    endtask

    task automatic test_backpressure;
        int e, e2, bad;
        bad = 0;
        shot_ready = 1'b0;
        press(4'd7, e);
        press(4'd0, e);
        exp_q.push_back('{r: 4'd7, c: 4'd0});
        press(4'hF, e);
        wait_valid("bp");
        repeat (10) begin @(negedge clk); if (shot_valid !== 1'b1 || shot_row !== 4'd7 || shot_col !== 4'd0) bad++; end
        press(4'd3, e);
        press(4'd3, e2);
        repeat (10) begin @(negedge clk); if (shot_valid !== 1'b1 || shot_row !== 4'd7 || shot_col !== 4'd0) bad++; end
        n_checks++;
        if (bad != 0 || e != 0 || e2 != 0 || shot_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL backpressure_hold: unstable_cycles=%0d errs=%0d/%0d v=%b, expected 0 0/0 1", bad, e, e2, shot_valid);
        end
        n_checks++;
        if (row_set !== 1'b1 || col_set !== 1'b1) begin
            n_fail++; $display("FAIL send_flags: rs=%b cs=%b, expected 1 1", row_set, col_set);
        end
        @(posedge clk); #1 shot_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (shot_valid !== 1'b0 || row_set !== 1'b0 || disp_row !== 4'd0) begin
            n_fail++; $display("FAIL bp_complete: v=%b rs=%b dr=%0d, expected 0 0 0", shot_valid, row_set, disp_row);
        end
    endtask

    task automatic test_reset_midway;
        int e;
        shot_ready = 1'b0;
        press(4'd5, e);
        press(4'd5, e);
        press(4'hF, e);
        wait_valid("rst_send");
        @(posedge clk); #1 rst_n = 1'b0;
        #1 check_all_zero("reset_in_send");
        @(negedge clk); rst_n = 1'b1;
        idle(8);
        shot_ready = 1'b1;
        press(4'd2, e);
        n_checks++;
        if (row_set !== 1'b1) begin
            n_fail++; $display("FAIL row_before_reset: rs=%b, expected 1", row_set);
        end
        @(posedge clk); #1 rst_n = 1'b0;
        #1 check_all_zero("reset_in_col");
        @(negedge clk); rst_n = 1'b1;
        idle(8);
    endtask

    task automatic test_entry_disabled;
        int e, e2;
        entry_en = 1'b0;
        press(4'd3, e);
        press(4'd9, e2);
        n_checks++;
        if (e != 0 || e2 != 0 || row_set !== 1'b0 || disp_row !== 4'd0) begin
            n_fail++;
            $display("FAIL entry_disabled: errs=%0d/%0d rs=%b dr=%0d, expected 0/0 0 0", e, e2, row_set, disp_row);
        end
        entry_en = 1'b1;
        press(4'd6, e);
        n_checks++;
        if (row_set !== 1'b1 || disp_row !== 4'd6) begin
            n_fail++; $display("FAIL entry_reenabled: rs=%b dr=%0d, expected 1 6", row_set, disp_row);
        end
    endtask

    initial begin
        test_reset();
        test_basic_shot();
        test_bounce();
        test_invalid();
        test_correction();
        test_backpressure();
        test_reset_midway();
        test_entry_disabled();
        idle(5);
        n_checks++;
        if (beats != 3 || exp_q.size() != 0) begin
            n_fail++; $display("FAIL shot_count: beats=%0d pending=%0d, expected 3 0", beats, exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
